seg_scan_shifter: RTL
=====================

Name: seg_scan_shifter

Overview:
- Downstream consumer of the four 16-bit display words produced by the binary-to-7-segment stage.
- Each word is {segment byte [15:8], digit-select byte [7:0]}.
- The block time-multiplexes the four words onto a serial 3-wire bus driving two cascaded 8-bit shift/latch registers (segment register first in chain).
- It shifts each word MSB-first, pulses the latch, holds for a dwell period, then advances to the next digit, cycling 0→1→2→3→0.

Parameters:
- CLK_DIV, 2: system clocks per ser_clk phase (low phase and high phase each last CLK_DIV cycles); legal range ≥1.
- DWELL, 50000: system clocks a latched digit is held before the next digit is loaded; legal range ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable.
- word_0  in  16  digit 0 word, {seg[7:0], sel[7:0]}.
- word_1  in  16  digit 1 word.
- word_2  in  16  digit 2 word.
- word_3  in  16  digit 3 word.
- ser_data  out  1  serial data, MSB first.
- ser_clk  out  1  shift clock; data is sampled externally on its rising edge.
- ser_latch  out  1  storage-register latch pulse, active high.
- busy  out  1  high in every state except IDLE.
- digit_idx  out  2  index of the digit being loaded or displayed.
- frame_done  out  1  one-cycle pulse when digit 3's dwell completes.

Behaviour:
- Single clock domain, clk. rst_n is asynchronous and active-low. No other reset.
- Reset values: ser_data=0, ser_clk=0, ser_latch=0, busy=0, digit_idx=0, frame_done=0. State goes to IDLE, all counters clear.
- States: IDLE, LOAD, SHIFT, LATCH, DWELL.
- IDLE:
  - All outputs are at their reset values, except digit_idx, which holds its last value.
  - When en=1, go to LOAD on the next edge.
- LOAD (1 cycle):
  - Capture word_<digit_idx> into a 16-bit shift register.
  - Drive ser_data = captured bit 15; ser_clk=0; bit counter = 0.
  - Go to SHIFT.
  - Input words are sampled only here. Changes at any other time do not affect the word in flight.
- SHIFT: 16 bits, each occupying 2*CLK_DIV cycles.
  - ser_clk=0 for CLK_DIV cycles, then ser_clk=1 for CLK_DIV cycles.
  - ser_data changes only on the cycle ser_clk falls (or in LOAD), so it is stable across every rising edge.
  - After the high phase of bit 15 (the 16th bit, LSB), go to LATCH.
- LATCH:
  - ser_clk=0 and ser_latch=1 for CLK_DIV cycles; ser_data=0.
  - Go to DWELL.
- DWELL:
  - DWELL cycles with all serial outputs at 0.
  - On the last cycle: digit_idx increments (3 wraps to 0).
  - If digit_idx was 3, frame_done=1 for exactly that cycle.
  - Then go to LOAD if en=1, else IDLE.
- Per-digit period is 1 + 32*CLK_DIV + CLK_DIV + DWELL cycles. With CLK_DIV=2 and DWELL=10 this is 77 cycles; a frame is 308 cycles.
- en deasserted mid-word: the current word finishes through LATCH and DWELL, so the display is never left with a partially shifted register. The block then enters IDLE.
- en reasserted during DWELL: no effect. The sequence continues normally.
- Reset mid-operation: asynchronous return to the reset state. The partial word is discarded, no latch pulse is emitted, and after rst_n releases, scanning restarts at digit 0.
- Counters:
  - Phase counter width is clog2(CLK_DIV)+1.
  - Dwell counter width is clog2(DWELL)+1.
  - Bit counter is 4 bits.
  - No counter may overflow or wrap within a state.

Optional Feature:
- Macro: SEG_ACTIVE_LOW_EN.
- Defined: the segment byte [15:8] is inverted at LOAD, for common-anode displays. The digit-select byte [7:0] is shifted unmodified.
- Undefined: the whole word is shifted exactly as received.

Test Plan:
- Reset values: CLK_DIV=2, DWELL=10. Hold rst_n=0 with en=1 → all outputs 0. Release rst_n → LOAD for digit 0 occurs on the first edge after release.
- Single word shift: word_0=16'hA502, en=1 → 16 ser_clk rising edges sample the sequence 1,0,1,0,0,1,0,1,0,0,0,0,0,0,1,0. ser_latch is high for 2 cycles, starting 65 cycles after LOAD.
- Frame order and timing: word_0..3 = 16'h1102, 16'h2204, 16'h3310, 16'h4420 → words latched in order 0,1,2,3,0. LOAD-to-LOAD spacing is 77 cycles. frame_done pulses once every 308 cycles, in the last DWELL cycle of digit 3.
- Input snapshot: change word_1 during digit 1 SHIFT → the shifted word_1 value equals the value at LOAD. The new value appears on the next frame.
- en drop: deassert en mid-SHIFT of digit 2 → digit 2 completes its latch and dwell. digit_idx becomes 3, busy falls, and no further ser_clk edges occur.
- Reset mid-shift: assert rst_n=0 during SHIFT bit 7 → outputs go to 0 asynchronously (same cycle) with no ser_latch pulse. After release, digit 0 is reloaded.
- With SEG_ACTIVE_LOW_EN defined: word_0=16'hA502 → shifted word is 16'h5A02.

Source files
------------

// File: rtl/seg_scan_shifter.sv
// Serial scan driver for four 16-bit {segment, digit-select} words into two cascaded shift/latch registers.
// Optional build macro SEG_ACTIVE_LOW_EN inverts the segment byte at load for common-anode displays.
`timescale 1ns/1ps
module seg_scan_shifter #(
  parameter int CLK_DIV = 2,
  parameter int DWELL   = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] word_0,
  input  logic [15:0] word_1,
  input  logic [15:0] word_2,
  input  logic [15:0] word_3,
  output logic        ser_data,
  output logic        ser_clk,
  output logic        ser_latch,
  output logic        busy,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int PH_W = $clog2(CLK_DIV) + 1;
  localparam int DW_W = $clog2(DWELL) + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);
  localparam logic [DW_W-1:0] DW_PRE  = DW_W'(DWELL - 2);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_DWELL} state_t;

  state_t            state;
  logic [14:0]       shreg;
  logic [PH_W-1:0]   phase_cnt;
  logic [DW_W-1:0]   dwell_cnt;
  logic [3:0]        bit_cnt;
  logic [15:0]       raw_word;
  logic [15:0]       load_word;

  // digit_idx is already advanced by the time a LOAD is entered, so it selects the word directly
  always_comb begin
    raw_word = word_0;
    case (digit_idx)
      2'd1:    raw_word = word_1;
      2'd2:    raw_word = word_2;
      2'd3:    raw_word = word_3;
      default: raw_word = word_0;
    endcase
`ifdef SEG_ACTIVE_LOW_EN
    load_word = {~raw_word[15:8], raw_word[7:0]};
`else
    load_word = raw_word;
`endif
  end

  // Only bits 14..0 are kept; bit 15 goes straight onto ser_data when the word is captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      phase_cnt  <= '0;
      dwell_cnt  <= '0;
      bit_cnt    <= '0;
      ser_data   <= 1'b0;
      ser_clk    <= 1'b0;
      ser_latch  <= 1'b0;
      busy       <= 1'b0;
      digit_idx  <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            state     <= S_LOAD;
            shreg     <= load_word[14:0];
            ser_data  <= load_word[15];
            ser_clk   <= 1'b0;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            phase_cnt <= '0;
          end
        end

        S_LOAD: begin
          state     <= S_SHIFT;
          phase_cnt <= '0;
        end

        S_SHIFT: begin
          if (phase_cnt == PH_LAST) begin
            phase_cnt <= '0;
            if (!ser_clk) begin
              ser_clk <= 1'b1;
            end else if (bit_cnt == 4'd15) begin
              state     <= S_LATCH;
              ser_clk   <= 1'b0;
              ser_latch <= 1'b1;
              ser_data  <= 1'b0;
            end else begin
              ser_clk  <= 1'b0;
              bit_cnt  <= bit_cnt + 4'd1;
              ser_data <= shreg[14];
              shreg    <= {shreg[13:0], 1'b0};
            end
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end

        S_LATCH: begin
          if (phase_cnt == PH_LAST) begin
            state     <= S_DWELL;
            ser_latch <= 1'b0;
            phase_cnt <= '0;
            dwell_cnt <= '0;
            // A single-cycle dwell is its own last cycle, so the advance happens on entry
            if (DWELL == 1) begin
              digit_idx  <= digit_idx + 2'd1;
              frame_done <= (digit_idx == 2'd3);
            end
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end

        S_DWELL: begin
          if (dwell_cnt == DW_LAST) begin
            frame_done <= 1'b0;
            dwell_cnt  <= '0;
            if (en) begin
              state     <= S_LOAD;
              shreg     <= load_word[14:0];
              ser_data  <= load_word[15];
              ser_clk   <= 1'b0;
              bit_cnt   <= '0;
              phase_cnt <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
            if (dwell_cnt == DW_PRE) begin
              digit_idx  <= digit_idx + 2'd1;
              frame_done <= (digit_idx == 2'd3);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
